// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with request/grant/response memory port,
// an IBUF_DEPTH-entry instruction buffer and redirect flush.
// Optional misaligned-fetch fault reporting is enabled by FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IBUF_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        INST_VALID,
  output logic [31:0] INST,
  output logic [31:0] INST_PC,
  input  logic        INST_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        INST_FAULT
`endif
);

  localparam int unsigned PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          halt_q, halt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   buf_data_q [IBUF_DEPTH];
  logic [31:0]   buf_pc_q   [IBUF_DEPTH];

  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic          valid_q, valid_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   inst_pc_q, inst_pc_d;

  logic          gnt;
  logic          pop;
  logic          push;
  logic [31:0]   push_data;
  logic [31:0]   push_pc;
  logic [31:0]   head_data;
  logic [31:0]   head_pc;
  logic          pc_misaligned;
  logic          next_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
  logic          buf_fault_q [IBUF_DEPTH];
  logic          fault_q, fault_d;
  logic          push_fault;
  logic          head_fault;

  assign pc_misaligned   = (fetch_pc_q[1:0] != 2'b00);
  assign next_misaligned = (fetch_pc_d[1:0] != 2'b00);
  assign INST_FAULT      = fault_q;
`else
  assign pc_misaligned   = 1'b0;
  assign next_misaligned = 1'b0;
`endif

  // A grant only counts while a request is actually on the bus.
  assign gnt = IMEM_GNT & req_q;
  assign pop = valid_q & INST_READY;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    halt_d     = halt_q;
    push       = 1'b0;
    push_data  = '0;
    push_pc    = '0;
`ifdef FETCH_ALIGN_CHECK_EN
    push_fault = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (!halt_q && (count_q < DEPTH_C)) state_d = S_REQ;
      end
      S_REQ: begin
        if (pc_misaligned) begin
          push    = 1'b1;
          push_pc = fetch_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
          push_fault = 1'b1;
`endif
          halt_d  = 1'b1;
          state_d = S_IDLE;
        end else if (gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (IMEM_RVALID) begin
          push      = 1'b1;
          push_data = IMEM_RDATA;
          push_pc   = req_pc_q;
          state_d   = ((count_q + CW'(1) - CW'(pop)) < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (IMEM_RVALID) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (REDIRECT) begin
      fetch_pc_d = REDIRECT_PC;
      halt_d     = 1'b0;
      push       = 1'b0;
      case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   state_d = gnt ? S_DROP : S_REQ;
        S_WAIT:  state_d = IMEM_RVALID ? S_REQ : S_DROP;
        // A stale response landing with the redirect retires the only
        // outstanding request, so staying in S_DROP would never exit.
        S_DROP:  state_d = IMEM_RVALID ? S_REQ : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    if (REDIRECT) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end

    // The registered head must reflect a word written this same cycle.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_data = push_data;
      head_pc   = push_pc;
    end else begin
      head_data = buf_data_q[rd_ptr_d];
      head_pc   = buf_pc_q[rd_ptr_d];
    end
`ifdef FETCH_ALIGN_CHECK_EN
    head_fault = (push && (wr_ptr_q == rd_ptr_d)) ? push_fault : buf_fault_q[rd_ptr_d];
`endif

    req_d     = (state_d == S_REQ) && !next_misaligned;
    addr_d    = fetch_pc_d & 32'hFFFF_FFFC;
    valid_d   = (count_d != '0);
    inst_d    = valid_d ? head_data : '0;
    inst_pc_d = valid_d ? head_pc   : '0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d   = valid_d ? head_fault : 1'b0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      halt_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      valid_q    <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      halt_q     <= halt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q    <= fault_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN && push) begin
      buf_data_q[wr_ptr_q]  <= push_data;
      buf_pc_q[wr_ptr_q]    <= push_pc;
`ifdef FETCH_ALIGN_CHECK_EN
      buf_fault_q[wr_ptr_q] <= push_fault;
`endif
    end
  end

  assign IMEM_REQ   = req_q;
  assign IMEM_ADDR  = addr_q;
  assign INST_VALID = valid_q;
  assign INST       = inst_q;
  assign INST_PC    = inst_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: instruction memory responder with
// programmable grant/response latency and a PC scoreboard on the decode side.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        INST_VALID;
  logic [31:0] INST;
  logic [31:0] INST_PC;
  logic        INST_READY = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        INST_FAULT;
`endif

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IBUF_DEPTH(2)
  ) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_GNT   (IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID),
    .IMEM_RDATA (IMEM_RDATA),
    .INST_VALID (INST_VALID),
    .INST       (INST),
    .INST_PC    (INST_PC),
    .INST_READY (INST_READY),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .INST_FAULT (INST_FAULT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Memory responder knobs and state
  int          grants_left = 0;
  int          gnt_delay   = 0;
  int          rsp_delay   = 0;
  int          req_wait    = 0;
  int          pend_cnt    = 0;
  int          n_grants    = 0;
  logic        pend        = 1'b0;
  logic [31:0] pend_addr   = '0;
  logic [31:0] gnt_addr    = '0;

  initial begin
    forever begin
      @(negedge CLK);
      if (IMEM_GNT) begin
        pend      = 1'b1;
        pend_cnt  = rsp_delay;
        pend_addr = gnt_addr;
        n_grants++;
      end
      IMEM_RVALID = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          IMEM_RVALID = 1'b1;
          IMEM_RDATA  = 32'h13 + pend_addr;
          pend        = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      IMEM_GNT = 1'b0;
      if (IMEM_REQ && !pend && grants_left > 0) begin
        if (req_wait >= gnt_delay) begin
          IMEM_GNT = 1'b1;
          gnt_addr = IMEM_ADDR;
          grants_left--;
          req_wait = 0;
        end else begin
          req_wait++;
        end
      end else begin
        req_wait = 0;
      end
    end
  end

  // Scoreboard: tests push expected PCs; each decode handshake pops one.
  logic [31:0] exp_q [$];
  int          pop_cyc [$];
  logic [31:0] mon_pc;

  always @(negedge CLK) begin
    #2;
    if (RSTN && INST_VALID && INST_READY) begin
      check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_pc = exp_q.pop_front();
        check_eq("inst_pc", INST_PC, mon_pc);
        check_eq("inst", INST, 32'h13 + mon_pc);
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("inst_fault", 32'(INST_FAULT), 32'd0);
`endif
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTN        = 1'b0;
    REDIRECT    = 1'b0;
    INST_READY  = 1'b0;
    grants_left = 0;
    gnt_delay   = 0;
    rsp_delay   = 0;
    exp_q.delete();
    pop_cyc.delete();
    tick();
    tick();
    RSTN = 1'b1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (IMEM_REQ) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq({tag, "_req"}, 32'(seen), 32'd1);
    if (seen) check_eq({tag, "_addr"}, IMEM_ADDR, exp_addr);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick();
    check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_gnt(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (IMEM_GNT) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq({tag, "_gnt"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int   lat;
  int   stable;
  int   base;
  logic seen_req;
  logic ok;

  initial begin
    // Reset values
    RSTN = 1'b0;
    tick();
    tick();
    check_eq("rst_req",   32'(IMEM_REQ), 32'd0);
    check_eq("rst_addr",  IMEM_ADDR, 32'h0);
    check_eq("rst_valid", 32'(INST_VALID), 32'd0);
    check_eq("rst_inst",  INST, 32'h0);
    check_eq("rst_pc",    INST_PC, 32'h0);

    // Zero-wait streaming: latency and throughput
    do_reset();
    grants_left = 4;
    INST_READY  = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (INST_VALID) begin
        lat = i;
        break;
      end
    end
    check_eq("t1_latency", 32'(lat), 32'd3);
    wait_drain("t1");
    check_eq("t1_pops", 32'(pop_cyc.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      if (pop_cyc.size() > i) check_eq("t1_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
    wait_req("t1_next", 32'h10);

    // Backpressure: buffer fills, requests stop, then drains
    do_reset();
    grants_left = 3;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int i = 0; i < 12; i++) tick();
    seen_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen_req |= IMEM_REQ;
      tick();
    end
    check_eq("t2_req_idle", 32'(seen_req), 32'd0);
    check_eq("t2_valid", 32'(INST_VALID), 32'd1);
    check_eq("t2_head_pc", INST_PC, 32'h0);
    check_eq("t2_head", INST, 32'h13);
    INST_READY = 1'b1;
    wait_req("t2_next", 32'h8);
    INST_READY = 1'b0;
    wait_drain("t2");

    // Delayed grant: request and address held stable
    do_reset();
    grants_left = 2;
    gnt_delay   = 3;
    INST_READY  = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (IMEM_REQ && IMEM_ADDR == 32'h4) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq("t3_reach", 32'(ok), 32'd1);
    stable = ok ? 1 : 0;
    for (int i = 0; i < 10 && ok; i++) begin
      tick();
      if (IMEM_REQ && IMEM_ADDR == 32'h4) stable++;
      else break;
    end
    check_eq("t3_stable", 32'(stable), 32'd4);
    wait_drain("t3");
    wait_req("t3_next", 32'h8);

    // Redirect while waiting for a response with one entry buffered
    do_reset();
    grants_left = 2;
    rsp_delay   = 3;
    base        = n_grants;
    ok          = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (n_grants == base + 2 && !IMEM_REQ) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq("t4_reach_wait", 32'(ok), 32'd1);
    check_eq("t4_buffered", 32'(INST_VALID), 32'd1);
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h100;
    tick();
    REDIRECT = 1'b0;
    check_eq("t4_flush", 32'(INST_VALID), 32'd0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    grants_left = 2;
    rsp_delay   = 0;
    INST_READY  = 1'b1;
    wait_req("t4_target", 32'h100);
    wait_drain("t4");

    // Redirect in the same cycle as a grant
    do_reset();
    grants_left = 2;
    INST_READY  = 1'b1;
    wait_gnt("t5");
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h200;
    exp_q.push_back(32'h200);
    tick();
    REDIRECT = 1'b0;
    check_eq("t5_flush", 32'(INST_VALID), 32'd0);
    wait_req("t5_target", 32'h200);
    wait_drain("t5");

    // Reset during S_WAIT; the late response must be ignored
    do_reset();
    INST_READY = 1'b1;
    tick();
    tick();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h40;
    tick();
    REDIRECT    = 1'b0;
    grants_left = 1;
    rsp_delay   = 4;
    wait_gnt("t6");
    tick();
    RSTN = 1'b0;
    tick();
    check_eq("t6_rst_req",   32'(IMEM_REQ), 32'd0);
    check_eq("t6_rst_addr",  IMEM_ADDR, 32'h0);
    check_eq("t6_rst_valid", 32'(INST_VALID), 32'd0);
    check_eq("t6_rst_inst",  INST, 32'h0);
    check_eq("t6_rst_pc",    INST_PC, 32'h0);
    RSTN        = 1'b1;
    rsp_delay   = 0;
    grants_left = 1;
    exp_q.push_back(32'h0);
    wait_req("t6_restart", 32'h0);
    wait_drain("t6");

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect produces a fault entry and halts fetch
    do_reset();
    tick();
    tick();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'h102;
    tick();
    REDIRECT = 1'b0;
    seen_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen_req |= IMEM_REQ;
      tick();
    end
    check_eq("t7_req_idle", 32'(seen_req), 32'd0);
    check_eq("t7_valid", 32'(INST_VALID), 32'd1);
    check_eq("t7_fault", 32'(INST_FAULT), 32'd1);
    check_eq("t7_pc", INST_PC, 32'h102);
    check_eq("t7_inst", INST, 32'h0);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
